// File: rtl/sti_rx_pkg.sv
// Shared types and frame-size constants for the serial-to-parallel receiver.
// Optional padding check is enabled with the STI_RX_PADCHK_EN macro.
package sti_rx_pkg;

    typedef enum logic [1:0] {
        LEN8  = 2'b00,
        LEN16 = 2'b01,
        LEN24 = 2'b10,
        LEN32 = 2'b11
    } len_e;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam logic [5:0] FRAME_BITS_8  = 6'd8;
    localparam logic [5:0] FRAME_BITS_16 = 6'd16;
    localparam logic [5:0] FRAME_BITS_24 = 6'd24;
    localparam logic [5:0] FRAME_BITS_32 = 6'd32;

    function automatic logic [5:0] frame_bits(input len_e len);
        logic [5:0] n;
        case (len)
            LEN8:    n = FRAME_BITS_8;
            LEN16:   n = FRAME_BITS_16;
            LEN24:   n = FRAME_BITS_24;
            default: n = FRAME_BITS_32;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sti_rx_unpack.sv
// Combinational word extraction from a bit-ordered frame; frame[0] is frame bit 0.
// Padding detection is only built when STI_RX_PADCHK_EN is defined.
module sti_rx_unpack
    import sti_rx_pkg::*;
(
    input  logic [31:0] frame,
    input  len_e        len,
    input  logic        fill,
    input  logic        low,
    output logic [15:0] word,
    output logic        pad_nonzero
);

    always_comb begin
        word = 16'h0000;
        case (len)
            LEN8:    word = low ? {frame[7:0], 8'h00} : {8'h00, frame[7:0]};
            LEN16:   word = frame[15:0];
            LEN24:   word = fill ? frame[23:8] : frame[15:0];
            default: word = fill ? frame[31:16] : frame[15:0];
        endcase
    end

`ifdef STI_RX_PADCHK_EN
    always_comb begin
        pad_nonzero = 1'b0;
        case (len)
            LEN24:   pad_nonzero = fill ? (frame[7:0] != 8'h00) : (frame[23:16] != 8'h00);
            LEN32:   pad_nonzero = fill ? (frame[15:0] != 16'h0000) : (frame[31:16] != 16'h0000);
            default: pad_nonzero = 1'b0;
        endcase
    end
`else
    assign pad_nonzero = 1'b0;
`endif

endmodule

// File: rtl/sti_rx.sv
// Serial frame receiver: collects 8/16/24/32-bit frames and presents a 16-bit word
// with a valid/ready handshake. STI_RX_PADCHK_EN enables the fill_err padding check.
//
//  state | meaning
//  IDLE  | waiting for the first valid bit of a frame; cfg_* sampled here
//  RECV  | collecting bits; a gap in si_valid aborts the frame
module sti_rx
    import sti_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_fill,
    input  logic        cfg_msb,
    input  logic        cfg_low,
    output logic [15:0] po_data,
    output logic        po_valid,
    input  logic        po_ready,
    output logic        frame_err,
    output logic        fill_err,
    output logic        overrun,
    output logic [7:0]  word_cnt
);

    state_e      state, state_nxt;
    logic [5:0]  bit_cnt;
    logic [31:0] shift_q, shift_nxt, frame_norm;
    len_e        len_q;
    logic        fill_q, msb_q, low_q;
    logic        frame_done, load_word;
    logic [15:0] word_unp;
    logic        pad_nz;

    assign frame_done = (state == RECV) && si_valid && ((bit_cnt + 6'd1) == frame_bits(len_q));
    assign load_word  = frame_done && (!po_valid || po_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (si_valid) state_nxt = RECV;
            RECV:    if (!si_valid || frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // MSB-first shifts left from bit 0; LSB-first shifts right from bit 31.
    always_comb begin
        if (state == IDLE)
            shift_nxt = cfg_msb ? {31'b0, si_data} : {si_data, 31'b0};
        else
            shift_nxt = msb_q ? {shift_q[30:0], si_data} : {si_data, shift_q[31:1]};
    end

    // LSB-first frames sit left-justified; bring frame bit 0 down to bit 0.
    always_comb begin
        frame_norm = shift_nxt;
        if (!msb_q) begin
            case (len_q)
                LEN8:    frame_norm = {24'b0, shift_nxt[31:24]};
                LEN16:   frame_norm = {16'b0, shift_nxt[31:16]};
                LEN24:   frame_norm = {8'b0, shift_nxt[31:8]};
                default: frame_norm = shift_nxt;
            endcase
        end
    end

    sti_rx_unpack u_unpack (
        .frame       (frame_norm),
        .len         (len_q),
        .fill        (fill_q),
        .low         (low_q),
        .word        (word_unp),
        .pad_nonzero (pad_nz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 6'd0;
            shift_q   <= 32'h0;
            len_q     <= LEN8;
            fill_q    <= 1'b0;
            msb_q     <= 1'b0;
            low_q     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (si_valid) begin
                        shift_q <= shift_nxt;
                        bit_cnt <= 6'd1;
                        len_q   <= len_e'(cfg_length);
                        fill_q  <= cfg_fill;
                        msb_q   <= cfg_msb;
                        low_q   <= cfg_low;
                    end
                end
                RECV: begin
                    if (!si_valid) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= 6'd0;
                        shift_q   <= 32'h0;
                    end else if (frame_done) begin
                        bit_cnt <= 6'd0;
                        shift_q <= 32'h0;
                    end else begin
                        shift_q <= shift_nxt;
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                default: bit_cnt <= 6'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            po_data  <= 16'h0000;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
            word_cnt <= 8'd0;
        end else if (frame_done) begin
            if (load_word) begin
                po_data  <= word_unp;
                po_valid <= 1'b1;
                word_cnt <= word_cnt + 8'd1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (po_valid && po_ready) begin
            po_valid <= 1'b0;
        end
    end

`ifdef STI_RX_PADCHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fill_err <= 1'b0;
        else       fill_err <= load_word && pad_nz;
    end
`else
    logic unused_pad_nz;
    assign unused_pad_nz = pad_nz;
    assign fill_err      = 1'b0;
`endif

endmodule

// File: tb/tb_sti_rx.sv
// Self-checking bench for sti_rx: directed frames plus randomized frames against
// a frame-level reference model (bit queue, arithmetic unpacking, handshake scoreboard).
module tb_sti_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        si_data, si_valid;
    logic [1:0]  cfg_length;
    logic        cfg_fill, cfg_msb, cfg_low;
    logic [15:0] po_data;
    logic        po_valid, po_ready;
    logic        frame_err, fill_err, overrun;
    logic [7:0]  word_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    sti_rx dut (
        .clk        (clk),
        .reset      (reset),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .cfg_length (cfg_length),
        .cfg_fill   (cfg_fill),
        .cfg_msb    (cfg_msb),
        .cfg_low    (cfg_low),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .po_ready   (po_ready),
        .frame_err  (frame_err),
        .fill_err   (fill_err),
        .overrun    (overrun),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_in;
    int          m_n;
    bit          m_fill, m_msb, m_low;
    bit          m_bits[$];
    logic [15:0] m_data;
    bit          m_valid, m_ovr, m_ferr, m_fill_err;
    logic [7:0]  m_cnt;

    function automatic void model_reset();
        m_in = 0; m_n = 8; m_bits.delete();
        m_data = 16'h0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_fill_err = 0; m_cnt = 8'd0;
    endfunction

    function automatic void model_complete();
        longint unsigned val = 0;
        longint unsigned pad = 0;
        logic [15:0] w;
        for (int i = 0; i < m_n; i++)
            if (m_bits[i]) val |= longint'(1) << (m_msb ? (m_n - 1 - i) : i);
        if (m_n == 8)       w = m_low ? 16'(val << 8) : 16'(val);
        else if (m_n == 16) w = 16'(val);
        else begin
            w   = m_fill ? 16'(val >> (m_n - 16)) : 16'(val);
            pad = m_fill ? (val & ((longint'(1) << (m_n - 16)) - 1)) : (val >> 16);
        end
        if (!m_valid || po_ready) begin
            m_data = w; m_valid = 1; m_cnt = m_cnt + 8'd1;
`ifdef STI_RX_PADCHK_EN
            m_fill_err = (pad != 0);
`endif
        end else begin
            m_ovr = 1;
        end
    endfunction

    function automatic void model_update();
        bit done = 0;
        if (reset) begin model_reset(); return; end
        m_ferr = 0; m_fill_err = 0;
        if (m_in) begin
            if (si_valid) begin
                m_bits.push_back(si_data);
                if (m_bits.size() == m_n) begin done = 1; m_in = 0; end
            end else begin
                m_ferr = 1; m_in = 0; m_bits.delete();
            end
        end else if (si_valid) begin
            m_n = 8 * (int'(cfg_length) + 1);
            m_fill = cfg_fill; m_msb = cfg_msb; m_low = cfg_low;
            m_bits.delete(); m_bits.push_back(si_data); m_in = 1;
        end
        if (done) model_complete();
        else if (m_valid && po_ready) m_valid = 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("po_valid",  32'(po_valid),  32'(m_valid));
        check("po_data",   32'(po_data),   32'(m_data));
        check("word_cnt",  32'(word_cnt),  32'(m_cnt));
        check("overrun",   32'(overrun),   32'(m_ovr));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("fill_err",  32'(fill_err),  32'(m_fill_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    // rdy values: 0/1 drive that level, 2 drives a random level
    task automatic send_bits(input int len, input bit fill, input bit msb, input bit low,
                             input logic [31:0] value, input int nb,
                             input int rdy_body, input int rdy_last);
        int n = 8 * (len + 1);
        int r;
        for (int i = 0; i < nb; i++) begin
            si_valid = 1'b1;
            si_data  = msb ? value[n - 1 - i] : value[i];
            if (i == 0) begin
                cfg_length = 2'(len); cfg_fill = fill; cfg_msb = msb; cfg_low = low;
            end else begin
                cfg_length = 2'($urandom); cfg_fill = 1'($urandom);
                cfg_msb = 1'($urandom); cfg_low = 1'($urandom);
            end
            r = (i == n - 1) ? rdy_last : rdy_body;
            po_ready = (r == 2) ? 1'($urandom) : r[0];
            tick();
        end
        si_valid = 1'b0;
        si_data  = 1'b0;
    endtask

    initial begin
        int len, nb, gaps;
        bit abort;
        reset = 1'b1; si_data = 0; si_valid = 0; cfg_length = 0;
        cfg_fill = 0; cfg_msb = 0; cfg_low = 0; po_ready = 0;
        model_reset();
        tick();
        check("rst_data", 32'(po_data), 32'h0);
        check("rst_cnt",  32'(word_cnt), 32'h0);
        reset = 1'b0;
        tick();

        send_bits(0, 0, 1, 0, 32'hA5, 8, 1, 1);
        check("len8_msb_data", 32'(po_data), 32'h00A5);
        check("len8_valid",    32'(po_valid), 32'h1);
        check("len8_cnt",      32'(word_cnt), 32'h1);

        send_bits(0, 0, 1, 1, 32'hA5, 8, 1, 1);
        check("len8_low_data", 32'(po_data), 32'hA500);

        send_bits(1, 0, 0, 0, 32'h1234, 16, 1, 1);
        check("len16_lsb_data", 32'(po_data), 32'h1234);

        send_bits(3, 1, 1, 0, 32'hBEEF0000, 32, 1, 1);
        check("len32_fill_data", 32'(po_data), 32'hBEEF);
        check("len32_pad_clean", 32'(fill_err), 32'h0);

        send_bits(3, 1, 1, 0, 32'hBEEF0001, 32, 1, 1);
        check("len32_pad_data", 32'(po_data), 32'hBEEF);
`ifdef STI_RX_PADCHK_EN
        check("len32_pad_err", 32'(fill_err), 32'h1);
`else
        check("len32_pad_err", 32'(fill_err), 32'h0);
`endif
        tick();
        check("pad_err_pulse", 32'(fill_err), 32'h0);

        po_ready = 1'b1;
        tick();
        send_bits(1, 0, 1, 0, 32'h5A5A, 5, 1, 1);
        tick();
        check("abort_ferr",  32'(frame_err), 32'h1);
        check("abort_valid", 32'(po_valid),  32'h0);
        tick();
        check("abort_pulse", 32'(frame_err), 32'h0);
        send_bits(1, 0, 1, 0, 32'h5A5A, 16, 1, 1);
        check("after_abort_data", 32'(po_data), 32'h5A5A);

        po_ready = 1'b1;
        tick();
        send_bits(0, 0, 1, 0, 32'h44, 8, 0, 0);
        send_bits(0, 0, 1, 0, 32'h55, 8, 0, 1);
        check("same_cycle_data",  32'(po_data),  32'h0055);
        check("same_cycle_valid", 32'(po_valid), 32'h1);
        check("same_cycle_ovr",   32'(overrun),  32'h0);
        send_bits(0, 0, 1, 0, 32'h11, 8, 1, 0);
        send_bits(0, 0, 1, 0, 32'h22, 8, 0, 0);
        check("ovr_data_held", 32'(po_data), 32'h0011);
        check("ovr_flag",      32'(overrun), 32'h1);
        po_ready = 1'b0;
        tick();
        check("ovr_sticky", 32'(overrun), 32'h1);

        send_bits(1, 0, 1, 0, 32'hC3C3, 5, 0, 0);
        #1 reset = 1'b1;
        #2;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
        tick();
        check("rst_mid_ferr", 32'(frame_err), 32'h0);
        check("rst_mid_ovr",  32'(overrun),   32'h0);

        for (int f = 0; f < 80; f++) begin
            len   = int'($urandom_range(0, 3));
            abort = ($urandom_range(0, 5) == 0);
            nb    = abort ? int'($urandom_range(1, 8 * (len + 1) - 1)) : 8 * (len + 1);
            send_bits(len, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, nb, 2, 2);
            gaps = abort ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                po_ready = 1'($urandom);
                tick();
            end
        end

        for (int f = 0; f < 260; f++)
            send_bits(0, 0, 1'($urandom), 1'($urandom), $urandom, 8, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
